// File: rtl/turn_signal_if.sv
// Switch, tick and LED bundle between the 2 Hz
// divider, the switch panel and the turn-signal controller.
interface turn_signal_if #(
  parameter int LED_W = 4
);
  logic             tick_2hz;
  logic             left_sw;
  logic             right_sw;
  logic             hazard_sw;
  logic             brake;
  logic [LED_W-1:0] led_left;
  logic [LED_W-1:0] led_right;
  logic [1:0]       mode;
  logic [7:0]       blink_cnt;

  modport master (
    output tick_2hz, left_sw, right_sw,
    output hazard_sw, brake,
    input  led_left, led_right, mode, blink_cnt
  );

  modport slave (
    input  tick_2hz, left_sw, right_sw,
    input  hazard_sw, brake,
    output led_left, led_right, mode, blink_cnt
  );
endinterface

// File: rtl/turn_signal_ctrl.sv
// Turn/hazard/brake arbitration and blink sequencing
// for the indicator LED banks, paced by the 2 Hz tick.
module turn_signal_ctrl #(
  parameter int LED_W    = 4,
  parameter int AUTO_OFF = 20
) (
  input  logic         clk,
  input  logic         rst,
  turn_signal_if.slave bus
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LEFT    = 3'd1;
  localparam logic [2:0] RIGHT   = 3'd2;
  localparam logic [2:0] HAZARD  = 3'd3;
  localparam logic [2:0] LOCKOUT = 3'd4;

  localparam bit         AUTO_EN  = (AUTO_OFF != 0);
  localparam logic [8:0] AUTO_LIM = 9'(AUTO_OFF);

  logic             s0_q, s1_q, s2_q;
  logic             rise;
  logic [2:0]       state_q, state_d, req;
  logic             phase_q, phase_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [8:0]       inc;
  logic             blinking;
  logic [LED_W-1:0] ledl_q, ledl_d;
  logic [LED_W-1:0] ledr_q, ledr_d;
  logic [LED_W-1:0] on_v, brk_v;
  logic [1:0]       mode_q, mode_d;

  assign rise = s1_q & ~s2_q;
  assign inc  = {1'b0, cnt_q} + 9'd1;
  assign blinking = (state_q == LEFT) ||
                    (state_q == RIGHT) ||
                    (state_q == HAZARD);

  always_comb begin
    req = IDLE;
    if (bus.hazard_sw || (bus.left_sw && bus.right_sw))
      req = HAZARD;
    else if (bus.left_sw)
      req = LEFT;
    else if (bus.right_sw)
      req = RIGHT;
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (state_q == LOCKOUT) begin
      if (req == HAZARD || req == IDLE)
        state_d = req;
    end else begin
      state_d = req;
    end
    // A state change swallows any rise on the same edge
    if (state_d != state_q) begin
      phase_d = 1'b1;
      cnt_d   = 8'd0;
    end else if (rise && blinking) begin
      phase_d = ~phase_q;
      if (!phase_q) begin
        cnt_d = inc[8] ? 8'hFF : inc[7:0];
        if (AUTO_EN && state_q != HAZARD &&
            inc == AUTO_LIM) begin
          state_d = LOCKOUT;
          cnt_d   = 8'd0;
          phase_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    on_v   = {LED_W{phase_d}};
    brk_v  = {LED_W{bus.brake}};
    ledl_d = brk_v;
    ledr_d = brk_v;
    unique case (state_d)
      LEFT:   ledl_d = on_v;
      RIGHT:  ledr_d = on_v;
      HAZARD: begin
        ledl_d = on_v;
        ledr_d = on_v;
      end
      default: ;
    endcase
    mode_d = (state_d == LOCKOUT) ? 2'b00
                                  : state_d[1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= IDLE;
      phase_q <= 1'b1;
      cnt_q   <= 8'd0;
      ledl_q  <= '0;
      ledr_q  <= '0;
      mode_q  <= 2'b00;
    end else begin
      s0_q    <= bus.tick_2hz;
      s1_q    <= s0_q;
      s2_q    <= s1_q;
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      ledl_q  <= ledl_d;
      ledr_q  <= ledr_d;
      mode_q  <= mode_d;
    end
  end

  assign bus.led_left  = ledl_q;
  assign bus.led_right = ledr_q;
  assign bus.mode      = mode_q;
  assign bus.blink_cnt = cnt_q;
endmodule

// File: tb/tb_turn_signal_ctrl.sv
// Directed bench for turn_signal_ctrl with
// LED_W=4, AUTO_OFF=3.
module tb_turn_signal_ctrl;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  turn_signal_if #(.LED_W(4)) bus();

  turn_signal_ctrl #(
    .LED_W(4),
    .AUTO_OFF(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Rise seen by LEDs on the 3rd edge; tail flushes the sync
  task automatic tick_pulse();
    bus.tick_2hz = 1'b1;
    step(3);
    bus.tick_2hz = 1'b0;
  endtask

  task automatic settle();
    step(3);
  endtask

  task automatic outs(input string tag,
                      input logic [3:0] l,
                      input logic [3:0] r,
                      input logic [1:0] m,
                      input logic [7:0] c);
    check({tag, ".ledl"}, 32'(bus.led_left),  32'(l));
    check({tag, ".ledr"}, 32'(bus.led_right), 32'(r));
    check({tag, ".mode"}, 32'(bus.mode),      32'(m));
    check({tag, ".cnt"},  32'(bus.blink_cnt), 32'(c));
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.tick_2hz  = 1'b0;
    bus.left_sw   = 1'b0;
    bus.right_sw  = 1'b0;
    bus.hazard_sw = 1'b0;
    bus.brake     = 1'b0;
    #3;
    outs("reset", 4'h0, 4'h0, 2'b00, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    step(2);
    outs("idle", 4'h0, 4'h0, 2'b00, 8'd0);

    // LEFT blinking up to auto-cancel
    bus.left_sw = 1'b1;
    step(1);
    outs("l_on", 4'hF, 4'h0, 2'b01, 8'd0);
    bus.tick_2hz = 1'b1;
    step(2);
    check("l_lat2", 32'(bus.led_left), 32'hF);
    step(1);
    check("l_lat3", 32'(bus.led_left), 32'h0);
    bus.tick_2hz = 1'b0;
    settle();
    tick_pulse(); settle();
    outs("l_c1", 4'hF, 4'h0, 2'b01, 8'd1);
    tick_pulse(); settle();
    outs("l_off2", 4'h0, 4'h0, 2'b01, 8'd1);
    tick_pulse(); settle();
    outs("l_c2", 4'hF, 4'h0, 2'b01, 8'd2);
    tick_pulse(); settle();
    tick_pulse(); settle();
    outs("lockout", 4'h0, 4'h0, 2'b00, 8'd0);
    tick_pulse(); settle();
    tick_pulse(); settle();
    outs("lock_hold", 4'h0, 4'h0, 2'b00, 8'd0);
    bus.left_sw = 1'b0;
    step(1);
    bus.right_sw = 1'b1;
    step(1);
    outs("right", 4'h0, 4'hF, 2'b10, 8'd0);
    bus.right_sw = 1'b0;
    step(1);
    outs("r_idle", 4'h0, 4'h0, 2'b00, 8'd0);

    // Hazard with brake: ten rises, no cancel
    bus.hazard_sw = 1'b1;
    bus.brake     = 1'b1;
    step(1);
    outs("haz_on", 4'hF, 4'hF, 2'b11, 8'd0);
    for (int i = 1; i <= 10; i++) begin
      tick_pulse(); settle();
      check($sformatf("haz_l%0d", i),
            32'(bus.led_left),
            (i % 2) ? 32'h0 : 32'hF);
      check($sformatf("haz_r%0d", i),
            32'(bus.led_right),
            (i % 2) ? 32'h0 : 32'hF);
    end
    outs("haz_end", 4'hF, 4'hF, 2'b11, 8'd5);

    // LEFT with brake, then hazard on a rise edge
    bus.hazard_sw = 1'b0;
    bus.left_sw   = 1'b1;
    step(1);
    outs("lb_on", 4'hF, 4'hF, 2'b01, 8'd0);
    tick_pulse(); settle();
    outs("lb_off", 4'h0, 4'hF, 2'b01, 8'd0);
    tick_pulse(); settle();
    outs("lb_c1", 4'hF, 4'hF, 2'b01, 8'd1);
    bus.tick_2hz = 1'b1;
    step(2);
    bus.hazard_sw = 1'b1;
    step(1);
    outs("haz_rise", 4'hF, 4'hF, 2'b11, 8'd0);
    bus.tick_2hz = 1'b0;
    settle();
    bus.hazard_sw = 1'b0;
    bus.left_sw   = 1'b0;
    bus.brake     = 1'b0;
    step(1);
    outs("idle2", 4'h0, 4'h0, 2'b00, 8'd0);

    // Both turn switches act as hazard
    bus.left_sw  = 1'b1;
    bus.right_sw = 1'b1;
    step(1);
    outs("both", 4'hF, 4'hF, 2'b11, 8'd0);
    tick_pulse(); settle();
    outs("both_off", 4'h0, 4'h0, 2'b11, 8'd0);
    bus.right_sw = 1'b0;
    step(1);
    outs("to_left", 4'hF, 4'h0, 2'b01, 8'd0);

    // Async reset mid OFF-phase, release with tick high
    bus.brake = 1'b1;
    tick_pulse(); settle();
    outs("pre_rst", 4'h0, 4'hF, 2'b01, 8'd0);
    bus.left_sw   = 1'b0;
    bus.hazard_sw = 1'b1;
    bus.brake     = 1'b0;
    bus.tick_2hz  = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    outs("async_rst", 4'h0, 4'h0, 2'b00, 8'd0);
    #1;
    rst = 1'b0;
    step(2);
    outs("rel_haz", 4'hF, 4'hF, 2'b11, 8'd0);
    step(1);
    outs("one_rise", 4'h0, 4'h0, 2'b11, 8'd0);
    step(10);
    outs("no_more", 4'h0, 4'h0, 2'b11, 8'd0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=done");
    $fatal(1, "timeout");
  end
endmodule
